// File: rtl/unsigned_16by8_divider_seq.sv
// ---------------------------------------------------------------------------
// unsigned_16by8_divider_seq
//
// Sequential restoring divider. It divides a DW-bit unsigned dividend by a
// VW-bit unsigned divisor and resolves one quotient bit per clock. Valid/ready
// handshakes are used on both the input side and the output side.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   in_valid     dividend/divisor presented by the producer
//   in_ready     high only in IDLE; an operation is accepted on in_valid&&in_ready
//   dividend     DW-bit unsigned dividend
//   divisor      VW-bit unsigned divisor
//   out_valid    result held in DONE until the consumer takes it
//   out_ready    consumer accepts the result
//   quotient     DW-bit unsigned quotient (ZQ on divide-by-zero)
//   remainder    VW-bit unsigned remainder (low dividend bits on divide-by-zero)
//   div_by_zero  the held result came from a divisor of 0
// ---------------------------------------------------------------------------
module unsigned_16by8_divider_seq #(
  parameter int              DW = 16,
  parameter int              VW = 8,
  parameter logic [DW-1:0]   ZQ = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] dividend_sr;
  logic [VW-1:0] divisor_r;
  logic [VW:0]   partial_rem;
  logic [CW-1:0] count;

  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;
  logic          trial_neg;
  logic [VW:0]   rem_next;
  logic [DW-1:0] q_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value is below 2*divisor. The extra top bit of diff is
  // therefore a clean borrow flag.
  always_comb begin
    shifted   = {1'b0, partial_rem[VW-1:0], dividend_sr[DW-1]};
    diff      = shifted - {2'b00, divisor_r};
    trial_neg = diff[VW+1];
    rem_next  = trial_neg ? shifted[VW:0] : diff[VW:0];
    q_next    = {dividend_sr[DW-2:0], ~trial_neg};
  end

  // The dividend shift register fills with quotient bits from the LSB as the
  // dividend bits leave through the MSB. After DW steps it holds the quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dividend_sr <= '0;
      divisor_r   <= '0;
      partial_rem <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dividend_sr <= dividend;
            divisor_r   <= divisor;
            partial_rem <= '0;
            count       <= CW'(DW);
            if (divisor == '0) begin
              quotient    <= ZQ;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dividend_sr <= q_next;
          partial_rem <= rem_next;
          count       <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= rem_next[VW-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/unsigned_16by8_divider_seq.md
Name: unsigned_16by8_divider_seq

Overview:
Sequential unsigned integer divider that performs the inverse operation of the 8x8 unsigned multiplier family. It divides a 16-bit dividend (a full product width) by an 8-bit divisor and returns the quotient and remainder. It uses a restoring shift-subtract algorithm that resolves one quotient bit per cycle. Valid/ready handshakes on both the input and output sides let it sit behind multiplier outputs in error-characterisation and round-trip test datapaths.

Parameters:
DW, 16, dividend and quotient width in bits
VW, 8, divisor and remainder width in bits (VW <= DW)
ZQ, all-ones of DW, quotient reported on divide-by-zero

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active high
in_valid  input  1  dividend/divisor presented
in_ready  output  1  block can accept an operation
dividend  input  DW  unsigned dividend
divisor  input  VW  unsigned divisor
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
quotient  output  DW  unsigned quotient
remainder  output  VW  unsigned remainder
div_by_zero  output  1  result came from a divisor of 0

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch dividend into a shift register and latch divisor.
  - Clear the partial remainder (VW+1 bits) and load the counter with DW.
  - If divisor==0, go to DONE with quotient=ZQ, remainder=dividend[VW-1:0], div_by_zero=1.
  - Otherwise go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, shift {partial_rem, dividend_sr} left by 1.
  - Compute trial = shifted partial_rem - {1'b0,divisor}.
  - If trial is non-negative, partial_rem=trial and the new quotient LSB=1. Else the new quotient LSB=0.
  - Decrement the counter. Exactly DW iterations run.
  - After the iteration where the counter reaches 0, go to DONE.
- Width rule: the partial remainder is VW+1 bits so the compare never overflows. The final remainder is always < divisor and fits in VW bits.
- DONE:
  - out_valid=1, with quotient, remainder and div_by_zero stable and held.
  - On out_valid&&out_ready, go to IDLE. On that edge out_valid drops to 0 and in_ready rises to 1.
  - Without out_ready, the block holds indefinitely with no change to the outputs.
- Latency:
  - Accept on edge E.
  - Normal operation: out_valid first high in the cycle after edge E+DW (17 cycles for DW=16).
  - Divide-by-zero: out_valid high in the cycle after edge E (latency 1).
- Throughput: at most one operation per DW+2 cycles. in_ready is never high while an operation is in flight (no overlap).
- Operand handling:
  - Inputs are sampled only on the accept edge.
  - Changes to dividend or divisor during CALC or DONE are ignored.
  - in_valid may be held high continuously. A new operation is accepted on the first IDLE cycle.
- Output registers: quotient/remainder/div_by_zero update only on entry to DONE. They keep their last values in IDLE and CALC. Consumers must qualify them with out_valid.
- Reset mid-operation:
  - rst in any state returns to IDLE with all reset values on the next edge.
  - The in-flight result is discarded and no out_valid pulse is produced.
  - rst has priority over every handshake on the same edge.
- Simultaneous events: in DONE, out_ready with in_valid high does not accept the new operation on the same edge. It is accepted one cycle later, in IDLE.
- Boundaries:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend=0 with divisor!=0 gives quotient=0, remainder=0, div_by_zero=0.

Test Plan:
- Basic: dividend=0x03E8 (1000), divisor=0x07, out_ready=1 -> out_valid in the 17th cycle after accept; quotient=0x008E (142), remainder=0x06, div_by_zero=0.
- Extremes: 0xFFFF/0xFF -> quotient=0x0101, remainder=0x00. Then 0x0005/0x09 -> quotient=0x0000, remainder=0x05. Then 0xABCD/0x01 -> quotient=0xABCD, remainder=0x00.
- Divide-by-zero: dividend=0x00C8, divisor=0x00 -> out_valid in the cycle after accept; quotient=0xFFFF, remainder=0xC8, div_by_zero=1.
- Backpressure: 0x1234/0x10 with out_ready=0 for 10 cycles after out_valid -> quotient=0x0123, remainder=0x04, held constant and in_ready=0 throughout. Raising out_ready -> exactly one transfer, and in_ready=1 on the next cycle.
- Reset mid-CALC: accept 0x8000/0x03, assert rst on the 5th CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0. A following 0x0064/0x0A -> quotient=0x000A, remainder=0x00.
- Back-to-back: in_valid held high with 0x0100/0x02 then 0x00FF/0x10, out_ready=1 -> two results in order, 0x0080 r0x00 and 0x000F r0x0F. The second is accepted exactly one cycle after the first output handshake.
